sfifo_prog: RTL and testbench
=============================

Name: sfifo_prog

Overview:
Synchronous single-clock FIFO for 24-bit audio sample streams, and the next generation of the team's basic sample FIFO. Adds an occupancy count, programmable almost-full/almost-empty thresholds, and a selectable read mode: standard registered read or first-word-fall-through (FWFT). Blocked pushes/pops are defined. Sits between the codec interface and the filter/processing pipeline wherever rate decoupling is needed.

Parameters:
WIDTH, 24, data word width in bits
N, 7, log2 of depth; depth D = 2**N words
AF_THRESH, 2**N-4, almost_full asserts when count >= AF_THRESH (1..D)
AE_THRESH, 4, almost_empty asserts when count <= AE_THRESH (0..D-1)
FWFT, 0, 0 = standard registered read port, 1 = first-word-fall-through

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous, active-high reset
write  in  1  push request
wdata  in  WIDTH  push data
read  in  1  pop request
rdata  out  WIDTH  read data
rvalid  out  1  rdata valid qualifier
full  out  1  count == D
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  N+1  current occupancy, 0..D

Behaviour:
- Storage: D x WIDTH array; read/write pointers of N bits wrap modulo D naturally; count is a separate N+1-bit register.
- Accepted push: wr_ok = write & ~full. Accepted pop: rd_ok = read & ~empty. Requests that are not accepted are ignored; state is unchanged.
- Count update: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither.
- Flags are decoded from the registered count only. They change in the cycle after the accepted operation and never depend combinationally on read/write.
- Full with read & write: pop accepted, push dropped; count goes D -> D-1.
- Empty with read & write: push accepted, pop ignored; count goes 0 -> 1.
- FWFT=0: on rd_ok, rdata <= mem[readptr] and rvalid <= 1 at the next edge (1-cycle latency). Otherwise rvalid <= 0 and rdata holds its last value.
- FWFT=1: rdata = mem[readptr] continuously; rvalid = ~empty; rd_ok consumes the displayed word. A word written at edge k is visible with rvalid=1 after edge k.
- Reset: pointers, count, rdata and rvalid go to 0. Flags read empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0 never, so 0). Memory is not cleared. Reset mid-stream discards all contents within one cycle.
- Reset has priority over write/read in the same cycle.
- Illegal parameters (AF_THRESH outside 1..D, AE_THRESH outside 0..D-1) are stopped with an elaboration-time $error.

Optional Feature:
Macro SFIFO_ERR_FLAGS_EN.
- Defined: adds input err_clr (1) and outputs overflow (1) and underflow (1).
  - overflow sets at the next edge on write & full & ~read, or write & full with a read that is not accepted.
  - underflow sets on read & empty.
  - Both are sticky until err_clr or rst. Set has priority over err_clr in the same cycle. Both reset to 0.
- Not defined: these ports and their logic are absent; blocked requests are silently ignored.

Test Plan:
- Reset, then push 0..19 with FWFT=0 -> count=20, almost_empty=0; 20 pops return 0..19 each with rvalid one cycle after read; count=0, empty=1.
- Fill with 128 pushes (data i) -> full=1 at count=128, almost_full=1 from count=124. Extra push of 0xABCDEF is dropped; the following pops return 0..127.
- Full, read & write together with wdata=0x555555 -> count=127, full=0; the last pop returns 127, not 0x555555.
- FWFT=1, push 0x000042 into empty FIFO -> next cycle rdata=0x000042, rvalid=1 with no read; read -> empty=1, rvalid=0.
- Continuous simultaneous read/write for 300 cycles starting at count=5 -> count stays 5; data order is preserved across pointer wrap.
- Assert rst at count=60 mid-stream -> next cycle count=0, empty=1, rvalid=0. With SFIFO_ERR_FLAGS_EN, a pop while empty sets underflow=1, which stays set until err_clr pulses.

Source files
------------

// File: rtl/sfifo_prog_if.sv
// Handshake/data bundle for sfifo_prog.
// Optional macro SFIFO_ERR_FLAGS_EN adds err_clr, overflow and underflow.
interface sfifo_prog_if #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned N     = 7
);
  logic             write;
  logic [WIDTH-1:0] wdata;
  logic             read;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [N:0]       count;
`ifdef SFIFO_ERR_FLAGS_EN
  logic             err_clr;
  logic             overflow;
  logic             underflow;

  modport master (
    output write, wdata, read, err_clr,
    input  rdata, rvalid, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
  modport slave (
    input  write, wdata, read, err_clr,
    output rdata, rvalid, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
`else
  modport master (
    output write, wdata, read,
    input  rdata, rvalid, full, empty, almost_full, almost_empty, count
  );
  modport slave (
    input  write, wdata, read,
    output rdata, rvalid, full, empty, almost_full, almost_empty, count
  );
`endif
endinterface

// File: rtl/sfifo_prog.sv
// Single-clock sample FIFO with occupancy count, programmable almost
// thresholds and selectable registered / first-word-fall-through read.
// Optional macro SFIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags.
module sfifo_prog #(
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned N         = 7,
  parameter int          AF_THRESH = 2**N - 4,
  parameter int          AE_THRESH = 4,
  parameter int unsigned FWFT      = 0
) (
  input logic         clk,
  input logic         rst,
  sfifo_prog_if.slave bus
);
  localparam int unsigned D       = 1 << N;
  localparam logic [N:0]  DEPTH_C = (N+1)'(D);
  localparam logic [N:0]  AF_C    = (N+1)'(AF_THRESH);
  localparam logic [N:0]  AE_C    = (N+1)'(AE_THRESH);

  if (AF_THRESH < 1 || AF_THRESH > int'(D)) begin : g_bad_af
    $error("sfifo_prog: AF_THRESH must lie in 1..2**N");
  end
  if (AE_THRESH < 0 || AE_THRESH > int'(D) - 1) begin : g_bad_ae
    $error("sfifo_prog: AE_THRESH must lie in 0..2**N-1");
  end

  logic [WIDTH-1:0] mem_q [D];
  logic [N-1:0]     wptr_q, wptr_d;
  logic [N-1:0]     rptr_q, rptr_d;
  logic [N:0]       count_q, count_d;
  logic             wr_ok, rd_ok;
  logic             full_w, empty_w;

  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);

  // Accept/ignore decisions and next pointer/count values.
  always_comb begin
    wr_ok   = bus.write & ~full_w;
    rd_ok   = bus.read & ~empty_w;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_ok) wptr_d = wptr_q + N'(1);
    if (rd_ok) rptr_d = rptr_q + N'(1);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (N+1)'(1);
      2'b01:   count_d = count_q - (N+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) mem_q[wptr_q] <= bus.wdata;
  end

  assign bus.count        = count_q;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);

  if (FWFT != 0) begin : g_fwft
    assign bus.rdata  = mem_q[rptr_q];
    assign bus.rvalid = ~empty_w;
  end else begin : g_reg
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;

    // Registered read: capture the head word on an accepted pop.
    always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = rd_ok;
      if (rd_ok) rdata_d = mem_q[rptr_q];
    end

    // Read-port output registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rdata_q  <= rdata_d;
        rvalid_q <= rvalid_d;
      end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
  end

`ifdef SFIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Sticky error flags; a new event wins over a simultaneous clear.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (bus.write & full_w & ~rd_ok) ovf_d = 1'b1;
    else if (bus.err_clr)            ovf_d = 1'b0;
    if (bus.read & empty_w)          unf_d = 1'b1;
    else if (bus.err_clr)            unf_d = 1'b0;
  end

  // Error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`endif
endmodule

// File: tb/tb_sfifo_prog.sv
// Bench for sfifo_prog: one registered-read and one FWFT instance share the
// same stimulus and are checked every cycle against a queue-based model.
module tb_sfifo_prog;
  localparam int WIDTH = 24;
  localparam int N     = 7;
  localparam int D     = 128;
  localparam int AF    = 124;
  localparam int AE    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             write, read;
  logic [WIDTH-1:0] wdata;
`ifdef SFIFO_ERR_FLAGS_EN
  logic             err_clr;
`endif

  always #5 clk = ~clk;

  sfifo_prog_if #(.WIDTH(WIDTH), .N(N)) bus0 ();
  sfifo_prog_if #(.WIDTH(WIDTH), .N(N)) bus1 ();

  assign bus0.write = write;
  assign bus0.wdata = wdata;
  assign bus0.read  = read;
  assign bus1.write = write;
  assign bus1.wdata = wdata;
  assign bus1.read  = read;
`ifdef SFIFO_ERR_FLAGS_EN
  assign bus0.err_clr = err_clr;
  assign bus1.err_clr = err_clr;
`endif

  sfifo_prog #(.WIDTH(WIDTH), .N(N), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0))
    u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  sfifo_prog #(.WIDTH(WIDTH), .N(N), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1))
    u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Reference model state
  logic [WIDTH-1:0] q[$];
  logic             m_rv0;
  logic [WIDTH-1:0] m_rd0;
  logic             m_ovf, m_unf;
  bit               chk_en = 0;
  int               checks = 0;
  int               errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: what the FIFO must hold after each edge.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_rv0 = 1'b0;
      m_rd0 = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      chk_en = 1;
    end else if (chk_en) begin
      bit is_full, is_empty, w_ok, r_ok;
      is_full  = (q.size() == D);
      is_empty = (q.size() == 0);
      w_ok = write && !is_full;
      r_ok = read && !is_empty;
`ifdef SFIFO_ERR_FLAGS_EN
      if (write && is_full && !r_ok) m_ovf = 1'b1;
      else if (err_clr)              m_ovf = 1'b0;
      if (read && is_empty)          m_unf = 1'b1;
      else if (err_clr)              m_unf = 1'b0;
`endif
      m_rv0 = r_ok;
      if (r_ok) m_rd0 = q.pop_front();
      if (w_ok) q.push_back(wdata);
    end
  end

  // Compare process: every output of both instances, each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      int sz;
      sz = q.size();
      chk("count0", 32'(bus0.count), 32'(sz));
      chk("count1", 32'(bus1.count), 32'(sz));
      chk("full",   32'(bus0.full),  32'(sz == D));
      chk("empty",  32'(bus0.empty), 32'(sz == 0));
      chk("almost_full",  32'(bus0.almost_full),  32'(sz >= AF));
      chk("almost_empty", 32'(bus0.almost_empty), 32'(sz <= AE));
      chk("rvalid0", 32'(bus0.rvalid), 32'(m_rv0));
      chk("rdata0",  32'(bus0.rdata),  32'(m_rd0));
      chk("rvalid1", 32'(bus1.rvalid), 32'(sz != 0));
      if (sz != 0) chk("rdata1", 32'(bus1.rdata), 32'(q[0]));
`ifdef SFIFO_ERR_FLAGS_EN
      chk("overflow",  32'(bus0.overflow),  32'(m_ovf));
      chk("underflow", 32'(bus0.underflow), 32'(m_unf));
`endif
    end
  end

  task automatic cyc(input logic w, input logic [WIDTH-1:0] d, input logic r);
    write = w;
    wdata = d;
    read  = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pw, pr;
    rst = 1'b1; write = 1'b0; read = 1'b0; wdata = '0;
`ifdef SFIFO_ERR_FLAGS_EN
    err_clr = 1'b0;
`endif
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    rst = 1'b0;
    chk("rst_count", 32'(bus0.count), 0);
    chk("rst_empty", 32'(bus0.empty), 1);
    chk("rst_ae",    32'(bus0.almost_empty), 1);
    chk("rst_af",    32'(bus0.almost_full), 0);
    chk("rst_rvalid", 32'(bus0.rvalid), 0);

    // Push 0..19 then pop them back
    for (int i = 0; i < 20; i++) cyc(1, 24'(i), 0);
    chk("c20_count", 32'(bus0.count), 20);
    chk("c20_ae", 32'(bus0.almost_empty), 0);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 1);
      chk("pop20_rvalid", 32'(bus0.rvalid), 1);
      chk("pop20_data", 32'(bus0.rdata), 32'(i));
    end
    cyc(0, 0, 0);
    chk("pop20_empty", 32'(bus0.empty), 1);
    chk("pop20_rv_low", 32'(bus0.rvalid), 0);

    // Fill to full, dropped push, drain
    for (int i = 0; i < D; i++) begin
      cyc(1, 24'(i), 0);
      if (i == AF - 2) chk("af_below", 32'(bus0.almost_full), 0);
      if (i == AF - 1) chk("af_at", 32'(bus0.almost_full), 1);
    end
    chk("fill_full", 32'(bus0.full), 1);
    chk("fill_count", 32'(bus0.count), 128);
    cyc(1, 24'hABCDEF, 0);
    chk("drop_count", 32'(bus0.count), 128);
`ifdef SFIFO_ERR_FLAGS_EN
    chk("ovf_set", 32'(bus0.overflow), 1);
    err_clr = 1'b1;
    cyc(0, 0, 0);
    err_clr = 1'b0;
    chk("ovf_clr", 32'(bus0.overflow), 0);
`endif
    for (int i = 0; i < D; i++) begin
      cyc(0, 0, 1);
      chk("drain_data", 32'(bus0.rdata), 32'(i));
    end

    // Full with simultaneous read and write
    for (int i = 0; i < D; i++) cyc(1, 24'(i), 0);
    cyc(1, 24'h555555, 1);
    chk("rw_full_count", 32'(bus0.count), 127);
    chk("rw_full_flag", 32'(bus0.full), 0);
    for (int i = 0; i < D - 1; i++) cyc(0, 0, 1);
    chk("rw_full_last", 32'(bus0.rdata), 127);
    cyc(0, 0, 0);

    // FWFT visibility
    cyc(1, 24'h000042, 0);
    chk("fwft_data", 32'(bus1.rdata), 32'h42);
    chk("fwft_valid", 32'(bus1.rvalid), 1);
    cyc(0, 0, 0);
    chk("fwft_hold", 32'(bus1.rdata), 32'h42);
    cyc(0, 0, 1);
    chk("fwft_empty", 32'(bus1.empty), 1);
    chk("fwft_rv_low", 32'(bus1.rvalid), 0);
    chk("reg_after_fwft", 32'(bus0.rdata), 32'h42);

    // Steady read+write across pointer wrap
    for (int i = 0; i < 5; i++) cyc(1, 24'($urandom), 0);
    for (int i = 0; i < 300; i++) cyc(1, 24'($urandom), 1);
    chk("steady_count", 32'(bus0.count), 5);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1);

    // Reset mid-stream, with a competing push/pop
    for (int i = 0; i < 60; i++) cyc(1, 24'($urandom), 0);
    chk("c60_count", 32'(bus0.count), 60);
    rst = 1'b1;
    cyc(1, 24'h123456, 1);
    rst = 1'b0;
    chk("mid_rst_count", 32'(bus0.count), 0);
    chk("mid_rst_empty", 32'(bus0.empty), 1);
    chk("mid_rst_rv0", 32'(bus0.rvalid), 0);
    chk("mid_rst_rv1", 32'(bus1.rvalid), 0);
`ifdef SFIFO_ERR_FLAGS_EN
    cyc(0, 0, 1);
    chk("unf_set", 32'(bus0.underflow), 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    chk("unf_sticky", 32'(bus0.underflow), 1);
    err_clr = 1'b1;
    cyc(0, 0, 1);
    chk("unf_set_wins", 32'(bus0.underflow), 1);
    cyc(0, 0, 0);
    err_clr = 1'b0;
    chk("unf_clr", 32'(bus0.underflow), 0);
`endif

    // Randomized traffic with varying write/read pressure
    pw = 50; pr = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) begin
        pw = int'($urandom_range(100));
        pr = int'($urandom_range(100));
      end
      rst = ($urandom_range(999) < 2);
`ifdef SFIFO_ERR_FLAGS_EN
      err_clr = ($urandom_range(49) == 0);
`endif
      cyc(int'($urandom_range(99)) < pw, 24'($urandom), int'($urandom_range(99)) < pr);
    end
    rst = 1'b0;
`ifdef SFIFO_ERR_FLAGS_EN
    err_clr = 1'b0;
`endif
    cyc(0, 0, 0);
    cyc(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
